// File: rtl/cla_nibble_serial_adder.sv
// Multi-precision adder/subtractor that runs one 4-bit carry look-ahead slice
// across a WIDTH-bit operand pair, one nibble per clock, least-significant first.

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded from the generate/propagate terms so no carry ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             c_out_q;
  logic             ovf_q;

  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_cout;
  logic [CW+1:0]    bit_base;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] b_d;
  logic             ovf_d;

  assign bit_base = {cnt_q, 2'b00};
  assign slice_a  = a_q[bit_base +: 4];
  assign slice_b  = b_q[bit_base +: 4];
  assign cnt_d    = cnt_q + CW'(1);
  assign b_d      = sub ? ~in2 : in2;

  // On the last nibble the slice's top sum bit is the final result MSB.
  assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_s[3] != a_q[WIDTH-1]);

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= in1;
            b_q     <= b_d;
            carry_q <= sub ? 1'b1 : c_in;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[bit_base +: 4] <= slice_s;
          carry_q              <= slice_cout;
          // The counter stops at the last nibble rather than wrapping.
          if (cnt_q == LAST) begin
            c_out_q <= slice_cout;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench for cla_nibble_serial_adder (WIDTH=16): expectations come
// from a full-width arithmetic model and are popped when done pulses.

module tb_cla_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .in1      (in1),
    .in2      (in2),
    .c_in     (c_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input logic ci);
    exp_t           e;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   t;
    bp   = s ? ~b : b;
    t    = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
    e.s  = t[WIDTH-1:0];
    e.co = t[WIDTH];
    e.ov = (a[WIDTH-1] == bp[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Drives a one-cycle start from a negedge and returns on the negedge after acceptance.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, input logic ci);
    @(negedge clk);
    in1   = a;
    in2   = b;
    sub   = s;
    c_in  = ci;
    start = 1'b1;
    sb.push_back(model(a, b, s, ci));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitForDone(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    c_in  = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, busy, done, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got ready=%b busy=%b done=%b sum=%h c_out=%b ovf=%b, expected 1 0 0 0000 0 0",
               ready, busy, done, sum, c_out, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: got ready=%b busy=%b, expected 1 0", ready, busy);
    end
  endtask

  task automatic test_arith;
    logic [WIDTH-1:0] va[10];
    logic [WIDTH-1:0] vb[10];
    logic             vs[10];
    logic             vc[10];
    int               cycles;
    bit               seen;
    exp_t             e;
    va[0] = 16'h1234; vb[0] = 16'h0FFF; vs[0] = 0; vc[0] = 0;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vs[1] = 0; vc[1] = 0;
    va[2] = 16'hFFFF; vb[2] = 16'h0000; vs[2] = 0; vc[2] = 1;
    va[3] = 16'h7FFF; vb[3] = 16'h0001; vs[3] = 0; vc[3] = 0;
    va[4] = 16'h8000; vb[4] = 16'h0001; vs[4] = 1; vc[4] = 0;
    va[5] = 16'h0005; vb[5] = 16'h0007; vs[5] = 1; vc[5] = 1;
    for (int i = 6; i < 10; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vs[i] = 1'($urandom_range(0, 1));
      vc[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(va[i], vb[i], vs[i], vc[i]);
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL run_flags[%0d]: got ready=%b busy=%b done=%b, expected 0 1 0", i, ready, busy, done);
      end
      waitForDone(cycles, seen);
      checks++;
      if (!seen || cycles != NIB) begin
        failures++;
        $display("[TB] FAIL latency[%0d]: got seen=%b cycles=%0d, expected 1 %0d", i, seen, cycles, NIB);
      end
      e = sb.pop_front();
      checks++;
      if ({sum, c_out, overflow} !== e) begin
        failures++;
        $display("[TB] FAIL result[%0d]: got sum=%h c_out=%b ovf=%b, expected sum=%h c_out=%b ovf=%b",
                 i, sum, c_out, overflow, e.s, e.co, e.ov);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || {sum, c_out, overflow} !== e) begin
        failures++;
        $display("[TB] FAIL hold[%0d]: got done=%b ready=%b sum=%h, expected 0 1 %h", i, done, ready, sum, e.s);
      end
    end
  endtask

  task automatic test_ignored_start;
    int   cycles;
    bit   seen;
    exp_t e;
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    in1   = 16'hAAAA;
    in2   = 16'h5555;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitForDone(cycles, seen);
    checks++;
    if (!seen || cycles != NIB - 2) begin
      failures++;
      $display("[TB] FAIL hs_latency: got seen=%b cycles=%0d, expected 1 %0d", seen, cycles, NIB - 2);
    end
    e = sb.pop_front();
    checks++;
    if ({sum, c_out, overflow} !== e) begin
      failures++;
      $display("[TB] FAIL hs_result: got sum=%h c_out=%b ovf=%b, expected sum=%h c_out=%b ovf=%b",
               sum, c_out, overflow, e.s, e.co, e.ov);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hs_done_start: got ready=%b busy=%b done=%b, expected 1 0 0", ready, busy, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || {sum, c_out, overflow} !== e) begin
      failures++;
      $display("[TB] FAIL hs_still_idle: got ready=%b sum=%h, expected 1 %h", ready, sum, e.s);
    end
  endtask

  task automatic test_back_to_back;
    int   cycles;
    bit   seen;
    exp_t e;
    @(negedge clk);
    in1   = 16'h0F0F;
    in2   = 16'h00F1;
    sub   = 1'b0;
    c_in  = 1'b1;
    start = 1'b1;
    sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0, 1'b1));
    @(negedge clk);
    in1  = 16'h4000;
    in2  = 16'hC001;
    sub  = 1'b1;
    c_in = 1'b0;
    sb.push_back(model(16'h4000, 16'hC001, 1'b1, 1'b0));
    waitForDone(cycles, seen);
    checks++;
    if (!seen || cycles != NIB) begin
      failures++;
      $display("[TB] FAIL b2b_latency1: got seen=%b cycles=%0d, expected 1 %0d", seen, cycles, NIB);
    end
    e = sb.pop_front();
    checks++;
    if ({sum, c_out, overflow} !== e) begin
      failures++;
      $display("[TB] FAIL b2b_result1: got sum=%h c_out=%b ovf=%b, expected sum=%h c_out=%b ovf=%b",
               sum, c_out, overflow, e.s, e.co, e.ov);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got done=%b ready=%b busy=%b, expected 0 1 0", done, ready, busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_accept: got ready=%b busy=%b, expected 0 1", ready, busy);
    end
    waitForDone(cycles, seen);
    checks++;
    if (!seen || cycles != NIB) begin
      failures++;
      $display("[TB] FAIL b2b_latency2: got seen=%b cycles=%0d, expected 1 %0d", seen, cycles, NIB);
    end
    e = sb.pop_front();
    checks++;
    if ({sum, c_out, overflow} !== e) begin
      failures++;
      $display("[TB] FAIL b2b_result2: got sum=%h c_out=%b ovf=%b, expected sum=%h c_out=%b ovf=%b",
               sum, c_out, overflow, e.s, e.co, e.ov);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_done_width: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_reset_mid_op;
    int   cycles;
    bit   seen;
    int   doneCount;
    exp_t e;
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    checks++;
    if ({ready, busy, done, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL async_reset: got ready=%b busy=%b done=%b sum=%h c_out=%b ovf=%b, expected 1 0 0 0000 0 0",
               ready, busy, done, sum, c_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checks++;
    if (doneCount != 0 || ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL no_done_after_abort: got done pulses=%0d ready=%b, expected 0 1", doneCount, ready);
    end
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    waitForDone(cycles, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL post_abort_done: got seen=%b, expected 1", seen);
    end
    e = sb.pop_front();
    checks++;
    if ({sum, c_out, overflow} !== e || sum !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL post_abort_result: got sum=%h c_out=%b ovf=%b, expected sum=%h c_out=%b ovf=%b",
               sum, c_out, overflow, e.s, e.co, e.ov);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
